// File: rtl/cache_line_fill.sv
// cache_line_fill: miss-handling engine placed in front of the cache line data memory.
// A miss request is accepted from IDLE. A dirty victim is first written back as four
// words (WB). The missing line is then read as four words and assembled (FILL). The
// line is written to the data memory in a single cycle, with a done pulse (WRITE).
//
// Optional build macro: CRITICAL_WORD_FIRST_EN
//   When defined, FILL starts at req_addr[3:2] and wraps modulo 4. The crit_valid and
//   crit_data outputs then report the first word returned.
//   When undefined, FILL order is 0,1,2,3 and the crit_* ports do not exist.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   miss request handshake; ready only while IDLE
//   req_addr              miss byte address: tag | index | word | byte
//   req_dirty             victim must be written back first
//   req_wb_tag            victim tag
//   req_wb_line           victim line data
//   mem_addr              word-aligned main memory address
//   mem_rd/mem_wr         main memory read/write request, held until mem_ack
//   mem_wdata             main memory write data
//   mem_rdata/mem_ack     main memory read data and its one-cycle completion pulse
//   line_w_addr/_data/_en data memory line write port
//   done                  one-cycle completion pulse, coincident with line_w_en
//   crit_valid/crit_data  (CRITICAL_WORD_FIRST_EN only) first returned fill word
module cache_line_fill #(
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              req_dirty,
    input  logic [ADDR_WIDTH-INDEX_WIDTH-5:0] req_wb_tag,
    input  logic [LINE_WIDTH-1:0]             req_wb_line,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output logic [WORD_WIDTH-1:0]             mem_wdata,
    input  logic [WORD_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_ack,
    output logic [INDEX_WIDTH-1:0]            line_w_addr,
    output logic [LINE_WIDTH-1:0]             line_w_data,
    output logic                              line_w_en,
    output logic                              done
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                              crit_valid,
    output logic [WORD_WIDTH-1:0]             crit_data
`endif
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 4;
    localparam int unsigned LSB_W     = $clog2(LINE_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // State and latched request
    logic [1:0]             state_q,   state_d;
    logic [1:0]             cnt_q,     cnt_d;
    logic [TAG_WIDTH-1:0]   tag_q,     tag_d;
    logic [INDEX_WIDTH-1:0]            idx_d;
    logic [TAG_WIDTH-1:0]   wb_tag_q,  wb_tag_d;
    logic [LINE_WIDTH-1:0]  wb_line_q, wb_line_d;
    logic [LINE_WIDTH-1:0]             line_d;

    // Next values of the registered outputs
    logic                   req_ready_d;
    logic                   mem_rd_d;
    logic                   mem_wr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [WORD_WIDTH-1:0]  mem_wdata_d;
    logic                   line_w_en_d;
    logic                   done_d;

    // Word slot currently being filled, and the slot the next request will target
    logic [1:0]             word_q;
    logic [1:0]             word_d;
    logic [LSB_W-1:0]       rd_lsb;
    logic [LSB_W-1:0]       wr_lsb;
    logic                   accept;

    // Byte offset bits are never needed; word bits are only used for critical-word-first
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^req_addr[3:0];

`ifdef CRITICAL_WORD_FIRST_EN
    logic [1:0]             w0_q, w0_d;
    assign word_q = w0_q + cnt_q;
`else
    assign word_q = cnt_q;
`endif

    assign accept = req_valid && req_ready;
    assign rd_lsb = LSB_W'(word_q) * LSB_W'(WORD_WIDTH);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        idx_d       = line_w_addr;
        wb_tag_d    = wb_tag_q;
        wb_line_d   = wb_line_q;
        line_d      = line_w_data;
`ifdef CRITICAL_WORD_FIRST_EN
        w0_d        = w0_q;
`endif
        req_ready_d = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        line_w_en_d = 1'b0;
        done_d      = 1'b0;
        word_d      = 2'd0;
        wr_lsb      = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tag_d     = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    idx_d     = req_addr[INDEX_WIDTH+3:4];
                    wb_tag_d  = req_wb_tag;
                    wb_line_d = req_wb_line;
`ifdef CRITICAL_WORD_FIRST_EN
                    w0_d      = req_addr[3:2];
`endif
                    cnt_d     = 2'd0;
                    state_d   = req_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    line_d[rd_lsb +: WORD_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
`ifdef CRITICAL_WORD_FIRST_EN
        word_d = w0_d + cnt_d;
`else
        word_d = cnt_d;
`endif
        wr_lsb      = LSB_W'(cnt_d) * LSB_W'(WORD_WIDTH);
        req_ready_d = (state_d == S_IDLE);
        mem_wr_d    = (state_d == S_WB);
        mem_rd_d    = (state_d == S_FILL);
        line_w_en_d = (state_d == S_WRITE);
        done_d      = (state_d == S_WRITE);
        if (state_d == S_WB) begin
            mem_addr_d  = {wb_tag_d, idx_d, cnt_d, 2'b00};
            mem_wdata_d = wb_line_d[wr_lsb +: WORD_WIDTH];
        end else if (state_d == S_FILL) begin
            mem_addr_d  = {tag_d, idx_d, word_d, 2'b00};
        end
    end

    // State and output registers; reset drops all requests and abandons any write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            tag_q       <= '0;
            wb_tag_q    <= '0;
            wb_line_q   <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            w0_q        <= 2'd0;
`endif
            req_ready   <= 1'b1;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            line_w_addr <= '0;
            line_w_data <= '0;
            line_w_en   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            wb_tag_q    <= wb_tag_d;
            wb_line_q   <= wb_line_d;
`ifdef CRITICAL_WORD_FIRST_EN
            w0_q        <= w0_d;
`endif
            req_ready   <= req_ready_d;
            mem_rd      <= mem_rd_d;
            mem_wr      <= mem_wr_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            line_w_addr <= idx_d;
            line_w_data <= line_d;
            line_w_en   <= line_w_en_d;
            done        <= done_d;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    // First fill word is forwarded in the same cycle its ack arrives
    assign crit_valid = (state_q == S_FILL) && mem_ack && (cnt_q == 2'd0);
    assign crit_data  = crit_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_cache_line_fill.sv
`timescale 1ns/1ps
module tb_cache_line_fill;

    localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] LINE_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         req_dirty = 1'b0;
    logic [19:0]  req_wb_tag = '0;
    logic [127:0] req_wb_line = '0;
    logic [31:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = 32'hDEAD_BEEF;
    logic         mem_ack = 1'b0;
    logic [7:0]   line_w_addr;
    logic [127:0] line_w_data;
    logic         line_w_en;
    logic         done;
`ifdef CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    cache_line_fill dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_dirty   (req_dirty),
        .req_wb_tag  (req_wb_tag),
        .req_wb_line (req_wb_line),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .line_w_addr (line_w_addr),
        .line_w_data (line_w_data),
        .line_w_en   (line_w_en),
        .done        (done)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid  (crit_valid),
        .crit_data   (crit_data)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Memory model state and logs
    int           mem_wait = 0;
    int           hold = 0;
    logic [31:0]  first_addr = '0;
    logic         first_rd = 1'b0;
    int           stable_err = 0;
    logic [31:0]  rd_data_q[$];
    logic [32:0]  op_log[$];
    logic [31:0]  wdata_log[$];

    // Monitor state
    int           both_err = 0;
    int           lw_cnt = 0;
    int           done_cnt = 0;
    logic [7:0]   lw_addr = '0;
    logic [127:0] lw_data = '0;
    int           crit_cnt = 0;
    logic [31:0]  crit_seen = '0;

    // Main memory: acks a held request after mem_wait extra cycles, logs each access
    always @(negedge clk) begin
        if (rst || !(mem_rd || mem_wr)) begin
            mem_ack   = 1'b0;
            hold      = 0;
            mem_rdata = 32'hDEAD_BEEF;
        end else begin
            if (hold == 0) begin
                first_addr = mem_addr;
                first_rd   = mem_rd;
            end else if (mem_addr !== first_addr || mem_rd !== first_rd) begin
                stable_err++;
            end
            if (hold >= mem_wait) begin
                mem_ack = 1'b1;
                hold    = 0;
                op_log.push_back({mem_rd, mem_addr});
                if (mem_rd) begin
                    if (rd_data_q.size() > 0) mem_rdata = rd_data_q.pop_front();
                    else mem_rdata = 32'hBAD0_0000;
                end else begin
                    wdata_log.push_back(mem_wdata);
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                mem_ack   = 1'b0;
                hold++;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Output monitor, sampled mid low phase after the memory model has settled
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (mem_rd && mem_wr) both_err++;
            if (line_w_en) begin
                lw_cnt++;
                lw_addr = line_w_addr;
                lw_data = line_w_data;
            end
            if (done) done_cnt++;
`ifdef CRITICAL_WORD_FIRST_EN
            if (crit_valid) begin
                crit_cnt++;
                crit_seen = crit_data;
            end
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic dirty,
                         input logic [19:0] wbtag, input logic [127:0] wbline);
        req_addr    = addr;
        req_dirty   = dirty;
        req_wb_tag  = wbtag;
        req_wb_line = wbline;
        req_valid   = 1'b1;
    endtask

    // Counts cycles from the issue cycle to the done cycle, with a cycle budget
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) req_valid = 1'b0;
        end while (!done && n < 200);
    endtask

    task automatic check_reads(input string tag, input int base_idx, input logic [31:0] a0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_rd%0d", tag, i), 128'(op_log[base_idx + i]),
                  128'({1'b1, a0 + 32'(4 * i)}));
        end
    endtask

    int n;
    int d0;
    int l0;
    int first_n;
    int second_n;
    int se0;

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_mem_rd", 128'(mem_rd), 128'(0));
        check("rst_mem_wr", 128'(mem_wr), 128'(0));
        check("rst_line_w_en", 128'(line_w_en), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_line_w_data", line_w_data, 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        rst = 1'b0;
        tick();

        // Clean miss, zero-wait memory
        rd_data_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        op_log.delete();
        d0 = done_cnt;
        issue(32'h0000_1230, 1'b0, 20'h0, 128'(0));
        wait_done(n);
        check("clean_latency", 128'(n), 128'(5));
        check("clean_ready_low_at_done", 128'(req_ready), 128'(0));
        tick();
        check("clean_ready_back", 128'(req_ready), 128'(1));
        check("clean_done_once", 128'(done_cnt - d0), 128'(1));
        check("clean_lw_addr", 128'(lw_addr), 128'(8'h23));
        check("clean_lw_data", lw_data, LINE_A);
        check("clean_nops", 128'(op_log.size()), 128'(4));
        check_reads("clean", 0, 32'h1230);

        // Dirty miss: write-back first, then fill
        rd_data_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        op_log.delete();
        wdata_log.delete();
        issue(32'h0000_1230, 1'b1, 20'h00005, LINE_B);
        wait_done(n);
        check("dirty_latency", 128'(n), 128'(9));
        check("dirty_nops", 128'(op_log.size()), 128'(8));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dirty_wr%0d", i), 128'(op_log[i]), 128'({1'b0, 32'h5230 + 32'(4 * i)}));
            check($sformatf("dirty_wd%0d", i), 128'(wdata_log[i]), 128'(32'hB0 + 32'(i)));
        end
        check_reads("dirty", 4, 32'h1230);
        check("dirty_lw_data", lw_data, LINE_A);
        tick();

        // Three wait states per word
        rd_data_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        op_log.delete();
        mem_wait = 3;
        se0 = stable_err;
        issue(32'h0000_1230, 1'b0, 20'h0, 128'(0));
        wait_done(n);
        check("wait_latency", 128'(n), 128'(17));
        check("wait_stable", 128'(stable_err - se0), 128'(0));
        check("wait_nops", 128'(op_log.size()), 128'(4));
        check_reads("wait", 0, 32'h1230);
        check("wait_lw_data", lw_data, LINE_A);
        mem_wait = 0;
        tick();

        // Back-to-back: valid held high, second accepted only once idle again
        rd_data_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
        op_log.delete();
        d0 = done_cnt;
        first_n = 0;
        second_n = 0;
        n = 0;
        issue(32'h0000_1230, 1'b0, 20'h0, 128'(0));
        while ((done_cnt - d0) < 2 && n < 300) begin
            tick();
            n++;
            if (n == 1) req_addr = 32'h0000_2FF0;
            if (n == 7) req_valid = 1'b0;
            if (done) begin
                if (first_n == 0) first_n = n;
                else second_n = n;
            end
        end
        check("b2b_first_done", 128'(first_n), 128'(5));
        check("b2b_second_done", 128'(second_n), 128'(11));
        check("b2b_nops", 128'(op_log.size()), 128'(8));
        check_reads("b2b_a", 0, 32'h1230);
        check_reads("b2b_b", 4, 32'h2FF0);
        check("b2b_lw_addr", 128'(lw_addr), 128'(8'hFF));
        check("b2b_lw_data", lw_data, LINE_C);
        tick();

        // Reset after the second fill ack
        rd_data_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        op_log.delete();
        d0 = done_cnt;
        l0 = lw_cnt;
        n = 0;
        issue(32'h0000_1230, 1'b0, 20'h0, 128'(0));
        do begin
            tick();
            n++;
            if (n == 1) req_valid = 1'b0;
        end while (op_log.size() < 2 && n < 50);
        check("rstmid_reached", 128'(op_log.size()), 128'(2));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_mem_rd", 128'(mem_rd), 128'(0));
        check("rstmid_req_ready", 128'(req_ready), 128'(1));
        check("rstmid_line_w_en", 128'(line_w_en), 128'(0));
        check("rstmid_done", 128'(done), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rstmid_no_write", 128'(lw_cnt - l0), 128'(0));
        check("rstmid_no_done", 128'(done_cnt - d0), 128'(0));
        check("rstmid_no_more_reads", 128'(op_log.size()), 128'(2));

        // A following request completes normally
        rd_data_q.delete();
        rd_data_q = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
        op_log.delete();
        issue(32'h0000_2FF0, 1'b0, 20'h0, 128'(0));
        wait_done(n);
        check("after_rst_latency", 128'(n), 128'(5));
        check("after_rst_lw_addr", 128'(lw_addr), 128'(8'hFF));
        check("after_rst_lw_data", lw_data, LINE_E);
        check_reads("after_rst", 0, 32'h2FF0);
        tick();

`ifdef CRITICAL_WORD_FIRST_EN
        // Critical word first: starts at word 2 and wraps
        rd_data_q = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        op_log.delete();
        d0 = crit_cnt;
        issue(32'h0000_1238, 1'b0, 20'h0, 128'(0));
        wait_done(n);
        check("cwf_latency", 128'(n), 128'(5));
        check("cwf_rd0", 128'(op_log[0]), 128'({1'b1, 32'h1238}));
        check("cwf_rd1", 128'(op_log[1]), 128'({1'b1, 32'h123C}));
        check("cwf_rd2", 128'(op_log[2]), 128'({1'b1, 32'h1230}));
        check("cwf_rd3", 128'(op_log[3]), 128'({1'b1, 32'h1234}));
        check("cwf_lw_data", lw_data, LINE_A);
        check("cwf_crit_pulses", 128'(crit_cnt - d0), 128'(1));
        check("cwf_crit_data", 128'(crit_seen), 128'(32'hA2));
        tick();
`endif

        check("never_rd_and_wr", 128'(both_err), 128'(0));
        check("held_stable_all", 128'(stable_err), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-handling engine that sits directly upstream of the cache line data memory (128-bit line, 8-bit index write port).
- On a miss request, it optionally writes back a dirty victim line to main memory as four 32-bit words.
- It then fetches four 32-bit words of the missing line from main memory and assembles them into a 128-bit line.
- Finally, it writes the line to the data memory in one cycle and pulses done.

Parameters:
INDEX_WIDTH, 8, line index bits; equals the data memory address width
LINE_WIDTH, 128, line bits; fixed at 4 x WORD_WIDTH
WORD_WIDTH, 32, main-memory data width
ADDR_WIDTH, 32, byte address width; offset [3:0], index [INDEX_WIDTH+3:4], tag the remaining upper bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  miss request valid
req_ready  out  1  engine idle, can accept
req_addr  in  ADDR_WIDTH  miss byte address
req_dirty  in  1  victim must be written back first
req_wb_tag  in  ADDR_WIDTH-INDEX_WIDTH-4  victim tag
req_wb_line  in  LINE_WIDTH  victim line data
mem_addr  out  ADDR_WIDTH  word-aligned memory address
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_wdata  out  WORD_WIDTH  write data
mem_rdata  in  WORD_WIDTH  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
line_w_addr  out  INDEX_WIDTH  data memory write index
line_w_data  out  LINE_WIDTH  assembled line
line_w_en  out  1  data memory write enable
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-high; the clock is clk and the reset is rst.
- Reset values: state=IDLE, req_ready=1, mem_rd=0, mem_wr=0, line_w_en=0, done=0, line_w_data=0, word counter=0, mem_addr=0, mem_wdata=0.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready.
  - On accept, latch req_addr, req_dirty, req_wb_tag and req_wb_line.
  - req_ready=0 from the next cycle until the cycle after done.
  - req_valid while busy is ignored.
- States:
  - IDLE -> WB if the latched dirty bit is 1, else FILL.
  - WB:
    - mem_wr=1.
    - mem_addr = {wb_tag, index, cnt, 2'b00}.
    - mem_wdata = wb_line[32*cnt +: 32].
    - On mem_ack, cnt++. After the ack for cnt=3, cnt=0 and state -> FILL.
  - FILL:
    - mem_rd=1.
    - mem_addr = {tag, index, word, 2'b00}, where word = cnt in base mode.
    - On mem_ack, mem_rdata is stored into line slot word [32*word +: 32], then cnt++. After the 4th ack, state -> WRITE.
  - WRITE (1 cycle):
    - line_w_en=1, done=1.
    - line_w_addr = latched index; line_w_data = assembled line.
    - Next state: IDLE.
- mem_rd and mem_wr are never high together. Both are held high with mem_addr stable until mem_ack. The next word's address appears the cycle after the ack, and the request stays asserted.
- mem_ack outside WB/FILL is ignored.
- Latency with a zero-wait memory (ack the cycle after request):
  - Clean miss: accept at T0, FILL at T1-T4, WRITE at T5, req_ready=1 at T6.
  - Dirty miss: four more cycles.
- Only the words of the current request are written; no stale data from a previous fill may leak.
  - All four slots are overwritten before WRITE, so no clearing is needed.
- The counter is 2 bits and wraps 3 -> 0.
- Reset mid-operation:
  - Outputs drop immediately; no line write and no done occur.
  - Any partially written-back victim is abandoned.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- When defined, FILL starts at the requested word w0 = req_addr[3:2] and wraps: word = (w0 + cnt) mod 4.
  - Example: w0=2 gives the order 2,3,0,1.
  - Adds output crit_valid (1 bit) and crit_data (WORD_WIDTH). crit_valid pulses with the first FILL ack, and crit_data = mem_rdata in that cycle.
  - Both are 0 at reset.
- When not defined: the order is always 0,1,2,3, and the crit_* ports do not exist.
- WB order is 0..3 in both builds.

Test Plan:
- Clean miss:
  - Stimulus: req_addr=0x0000_1230, zero-wait memory returning 0xA0,0xA1,0xA2,0xA3.
  - Required response: mem_addr 0x1230,0x1234,0x1238,0x123C; line_w_addr=0x23; line_w_data=0x000000A3_000000A2_000000A1_000000A0; done pulses once.
- Dirty miss:
  - Stimulus: req_dirty=1, wb_tag=0x00005, index=0x23, wb_line word i=0xB0+i.
  - Required response: writes 0xB0..0xB3 to 0x5230..0x523C, then reads from 0x1230; no mem_rd during WB.
- Wait states: mem_ack delayed 3 cycles per word -> mem_addr and mem_rd held stable throughout; the result equals the clean-miss case.
- Back-to-back requests:
  - Stimulus: req_valid held high with a second address 0x0000_2FF0.
  - Required response: the second request is accepted only after done; line_w_addr=0xFF; no data from the first line.
- Reset mid-operation:
  - Stimulus: rst asserted after the 2nd FILL ack.
  - Required response: mem_rd=0 and req_ready=1 immediately; no line_w_en. A following request completes normally.
- CRITICAL_WORD_FIRST_EN:
  - Stimulus: req_addr=0x0000_1238.
  - Required response: read order 0x1238,0x123C,0x1230,0x1234; crit_valid pulses with the first word; the assembled line matches the base-mode line.
